mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 single-bit multiplexer between four requesters. Each requester raises a request line. The arbiter grants exactly one requester at a time and drives the mux select so that requester's input reaches the mux output. A hold limit prevents any one requester from starving the others. The block sits directly in front of the 4:1 mux: its `sel` output connects to the mux `sel` input.

---
 rtl/mux4_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 single-bit mux: one-hot registered grant,
// mux select that tracks the owner, and an optional per-tenure hold limit.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [7:0] HOLD = MAX_HOLD[7:0];

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic [1:0] r_sel,   w_sel_nxt;

  logic       w_found;
  logic [1:0] w_winner;
  logic       w_at_limit;
  logic       w_others;
  logic       w_release;

  // Rotating priority search: r_ptr first, the previous owner last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && req[r_ptr + 2'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 2'(i);
      end
    end
  end

  assign w_at_limit = (HOLD != 8'd0) && (r_cnt == HOLD);
  assign w_others   = |(req & ~r_gnt);
  assign w_release  = !req[r_owner] || (w_at_limit && w_others);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_winner;
          w_gnt_nxt   = 4'b0001 << w_winner;
          w_sel_nxt   = w_winner;
          w_cnt_nxt   = 8'd1;
          w_ptr_nxt   = w_winner + 2'd1;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          if (w_found) begin
            w_owner_nxt = w_winner;
            w_gnt_nxt   = 4'b0001 << w_winner;
            w_sel_nxt   = w_winner;
            w_cnt_nxt   = 8'd1;
            w_ptr_nxt   = w_winner + 2'd1;
          end else begin
            // sel deliberately kept so the mux output does not glitch while idle
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end else if (w_at_limit) begin
          w_cnt_nxt = 8'd1;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = |r_gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: three instances cover default, MAX_HOLD=4
// and unlimited hold; expected values are hand-derived per stimulus step.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req8, req4, req0;
  logic [3:0] gnt8, gnt4, gnt0;
  logic [1:0] sel8, sel4, sel0;
  logic       valid8, valid4, valid0;

  int unsigned n_checks;
  int unsigned n_pass;

  mux4_rr_arbiter dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .sel(sel8), .valid(valid8)
  );

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .sel(sel4), .valid(valid4)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .sel(sel0), .valid(valid0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] own;
    n_checks = 0;
    n_pass   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    req8  = '0;
    req4  = '0;
    req0  = '0;

    // Reset state
    #3;
    check("rst_gnt",   8'(gnt8),   8'h00);
    check("rst_sel",   8'(sel8),   8'h00);
    check("rst_valid", 8'(valid8), 8'h00);
    check("rst_ptr",   8'(dut8.r_ptr), 8'h00);
    #10 rst_n = 1'b1;

    // Single request on input c
    req8 = 4'b0100;
    tick();
    check("single_gnt",   8'(gnt8),   8'h04);
    check("single_sel",   8'(sel8),   8'h02);
    check("single_valid", 8'(valid8), 8'h01);
    repeat (4) tick();
    check("single_hold_gnt", 8'(gnt8), 8'h04);
    req8 = 4'b0000;
    tick();
    check("single_idle_gnt",   8'(gnt8),   8'h00);
    check("single_idle_valid", 8'(valid8), 8'h00);
    check("single_idle_sel",   8'(sel8),   8'h02);

    // Round-robin wrap from reset with all four requesting
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req8 = 4'b1111;
    tick();
    check("rr_first_gnt", 8'(gnt8), 8'h01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_hold%0d_gnt", k), 8'(gnt8), 8'(4'b0001 << k));
      req8[k] = 1'b0;
      tick();
      check($sformatf("rr_next%0d_gnt", k),   8'(gnt8),   8'(4'b0001 << ((k + 1) % 4)));
      check($sformatf("rr_next%0d_sel", k),   8'(sel8),   8'((k + 1) % 4));
      check($sformatf("rr_next%0d_valid", k), 8'(valid8), 8'h01);
      req8[k] = 1'b1;
    end
    req8 = 4'b0000;
    tick();
    check("rr_idle_valid", 8'(valid8), 8'h00);

    // Hold limit 4 with two competitors
    req4 = 4'b0011;
    for (int t = 1; t <= 12; t++) begin
      tick();
      own = 2'(((t - 1) / 4) % 2);
      check($sformatf("hold_t%0d_gnt", t), 8'(gnt4), 8'(4'b0001 << own));
      check($sformatf("hold_t%0d_ptr", t), 8'(dut4.r_ptr), 8'(own + 2'd1));
    end
    req4 = 4'b0000;
    tick();
    check("hold_idle_gnt", 8'(gnt4), 8'h00);

    // Lone owner at the limit keeps the grant, counter wraps 1..4
    req4 = 4'b1000;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("lone_t%0d_gnt", t), 8'(gnt4), 8'h08);
      check($sformatf("lone_t%0d_cnt", t), dut4.r_cnt, 8'(((t - 1) % 4) + 1));
    end
    req4 = 4'b0000;
    tick();
    check("lone_idle_valid", 8'(valid4), 8'h00);

    // Owner drops on the same edge its limit is reached
    req4 = 4'b0011;
    repeat (4) tick();
    check("simul_pre_gnt", 8'(gnt4), 8'h01);
    check("simul_pre_cnt", dut4.r_cnt, 8'h04);
    req4 = 4'b0010;
    tick();
    check("simul_gnt", 8'(gnt4), 8'h02);
    check("simul_cnt", dut4.r_cnt, 8'h01);
    check("simul_ptr", 8'(dut4.r_ptr), 8'h02);
    tick();
    check("simul_keep_gnt", 8'(gnt4), 8'h02);
    req4 = 4'b0000;

    // Unlimited hold
    req0 = 4'b0011;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("unl_t%0d_gnt", t), 8'(gnt0), 8'h01);
    end
    check("unl_cnt", dut0.r_cnt, 8'd20);
    req0 = 4'b0010;
    tick();
    check("unl_handover_gnt", 8'(gnt0), 8'h02);
    check("unl_handover_sel", 8'(sel0), 8'h01);

    // Reset mid-grant clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    check("midrst_gnt",   8'(gnt0),   8'h00);
    check("midrst_sel",   8'(sel0),   8'h00);
    check("midrst_valid", 8'(valid0), 8'h00);
    check("midrst_ptr",   8'(dut0.r_ptr), 8'h00);
    #1 rst_n = 1'b1;
    tick();
    check("postrst_gnt", 8'(gnt0), 8'h02);
    check("postrst_sel", 8'(sel0), 8'h01);
    check("postrst_ptr", 8'(dut0.r_ptr), 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
